joypad_debounced_controller: RTL and testbench
==============================================

JOYPAD_DEBOUNCED_CONTROLLER -- requirements
Module: joypad_debounced_controller

Interface
REQ-001 Parameters (one per line: name, default, meaning):
  ADDR  16'hFF00  bus address of the JOYP register.
  SYNC_STAGES  2  synchroniser flops per raw key input (>=2).
  DB_CNT_W  10  debounce counter width; a key must be stable for 2^DB_CNT_W cycles before it is accepted.
REQ-002 Ports (one per line: name  direction  width  meaning):
  clock  in  1  single system clock; all state on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  A  in  16  CPU address.
  Di  in  8  CPU write data.
  Do  out  8  CPU read data.
  rd_n  in  1  read strobe, active low.
  wr_n  in  1  write strobe, active low.
  cs  in  1  register chip select.
  int_ack  in  1  interrupt acknowledge, active-high level.
  int_req  out  1  joypad interrupt request.
  dir_n  in  4  raw asynchronous direction keys, 0 = pressed: [3] Down, [2] Up, [1] Left, [0] Right.
  btn_n  in  4  raw asynchronous action keys, 0 = pressed: [3] Start, [2] Select, [1] B, [0] A.
  button_sel  out  2  registered select bits: [1] = JOYP bit 5 (action keys), [0] = JOYP bit 4 (direction keys), 0 = selected.
  key_state  out  8  debounced key vector {btn, dir}, 0 = pressed.

Function
REQ-003 Each of the 8 raw key bits SHALL pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-004 Each key SHALL have a stable bit and a DB_CNT_W-bit counter.
REQ-005 When the synchronised bit equals the stable bit, the counter SHALL clear to 0.
REQ-006 When the synchronised bit differs from the stable bit and the counter is below all-ones, the counter SHALL increment.
REQ-007 When the synchronised bit differs and the counter is all-ones, the stable bit SHALL take the synchronised value and the counter SHALL clear.
REQ-008 An input glitch shorter than 2^DB_CNT_W cycles SHALL never change the stable bit.
REQ-009 key_state SHALL equal {stable btn[3:0], stable dir[3:0]}.
REQ-010 A write SHALL occur on every clock edge where wr_n = 0, cs = 1 and A = ADDR.
REQ-011 A write SHALL load button_sel <= Di[5:4]; all other Di bits SHALL be ignored.
REQ-012 Nibble bit i SHALL equal (button_sel[0] | dir_i) & (button_sel[1] | btn_i), using debounced values.
REQ-013 Do SHALL be combinational: Do = {2'b11, button_sel, nibble} when cs = 1, else 8'hFF; rd_n SHALL NOT gate Do.
REQ-014 A registered copy of the previous-cycle nibble SHALL be kept.
REQ-015 int_req SHALL set on the edge after any nibble bit goes from 1 to 0.
REQ-016 The falling edge in REQ-015 SHALL count whether it comes from a debounced key press or from a button_sel write.
REQ-017 int_req SHALL clear on an edge with int_ack = 1 and no new falling edge.
REQ-018 If a new falling edge and int_ack = 1 occur on the same edge, int_req SHALL remain 1 (set wins).
REQ-019 int_req SHALL stay high until acknowledged, with no timeout; additional falling edges while it is high have no further effect.
REQ-020 A 0-to-1 nibble transition (key release) SHALL NOT raise int_req.

Reset
REQ-021 On reset_n = 0, immediately and asynchronously: synchroniser flops = 1, stable bits = 1, counters = 0, previous nibble = 4'hF, button_sel = 2'b11, int_req = 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; after release a key still held down needs the full SYNC_STAGES + 2^DB_CNT_W cycles to register.
REQ-023 Release of reset_n SHALL be usable asynchronously; no state SHALL change on the first edge after release other than the normal synchroniser shift.

Verification (DB_CNT_W = 4, SYNC_STAGES = 2)
REQ-024 Reset: after reset, cs = 1 -> Do = 8'hFF, int_req = 0, key_state = 8'hFF.
REQ-025 Debounce:
  - Write Di = 8'h20 (directions selected), then hold dir_n = 4'b1110.
  - Expect Do[3:0] = 4'hE exactly 2 + 16 cycles after the input change.
  - Expect int_req = 1 one cycle later.
REQ-026 Glitch: dir_n[0] low for 10 cycles, then high -> key_state and int_req unchanged.
REQ-027 Ack race:
  - Raise int_ack on the same edge as a new press of btn_n[0] with Di = 8'h10 written.
  - Expect int_req to stay 1.
  - Expect int_ack alone on the next edge to clear it.
REQ-028 Select-induced interrupt: hold btn_n = 4'b0111 debounced with button_sel = 2'b11, then write 8'h10 -> Do = 8'hD7 and int_req = 1.
REQ-029 Address and chip select:
  - A write to ADDR+1 leaves button_sel unchanged.
  - cs = 0 gives Do = 8'hFF.
  - Asserting reset_n = 0 mid-count, then releasing it, restarts the full debounce delay.

Source files
------------

// File: rtl/joypad_debounced_controller.sv
// joypad_debounced_controller: joypad register with per-key synchronisation and debounce.
// A select-gated nibble is read back, and its falling edges raise int_req.

module joypad_key_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 10
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_n,
    output logic stable_n
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_CNT_W-1:0]    cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_n <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
            if (synced == stable_n) begin
                cnt_q <= '0;
            end else if (cnt_q == '1) begin
                // 2^DB_CNT_W consecutive disagreeing samples: accept the new level
                stable_n <= synced;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + DB_CNT_W'(1);
            end
        end
    end
endmodule

module joypad_debounced_controller #(
    parameter logic [15:0] ADDR        = 16'hFF00,
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_CNT_W    = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        cs,
    input  logic        int_ack,
    output logic        int_req,
    input  logic [3:0]  dir_n,
    input  logic [3:0]  btn_n,
    output logic [1:0]  button_sel,
    output logic [7:0]  key_state
);
    localparam int NUM_KEYS = 8;

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
    } joyp_wr_t;

    logic [NUM_KEYS-1:0] raw_n;
    logic [NUM_KEYS-1:0] stable_n;
    logic [3:0]          dir_db;
    logic [3:0]          btn_db;
    logic [3:0]          nibble;
    logic [3:0]          prev_nibble;
    logic                fall;
    joyp_wr_t            wr;
    logic                unused_ok;

    assign raw_n = {btn_n, dir_n};

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
            joypad_key_debounce #(
                .SYNC_STAGES(SYNC_STAGES),
                .DB_CNT_W   (DB_CNT_W)
            ) u_key (
                .clock   (clock),
                .reset_n (reset_n),
                .raw_n   (raw_n[g]),
                .stable_n(stable_n[g])
            );
        end
    endgenerate

    assign key_state = stable_n;
    assign dir_db    = stable_n[3:0];
    assign btn_db    = stable_n[7:4];

    // Writes are edge-qualified by wr_n only; rd_n plays no part in the register
    assign wr.en  = ~wr_n & cs & (A == ADDR);
    assign wr.sel = Di[5:4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            button_sel <= 2'b11;
        end else if (wr.en) begin
            button_sel <= wr.sel;
        end
    end

    assign nibble = ({4{button_sel[0]}} | dir_db) & ({4{button_sel[1]}} | btn_db);
    assign Do     = cs ? {2'b11, button_sel, nibble} : 8'hFF;

    // Any 1->0 on the visible nibble interrupts, whether caused by a key or a select write
    assign fall = |(prev_nibble & ~nibble);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_nibble <= 4'hF;
            int_req     <= 1'b0;
        end else begin
            prev_nibble <= nibble;
            if (fall) begin
                int_req <= 1'b1;
            end else if (int_ack) begin
                int_req <= 1'b0;
            end
        end
    end

    assign unused_ok = &{1'b0, rd_n, Di[7:6], Di[3:0]};
endmodule

// File: tb/tb_joypad_debounced_controller.sv
// Bench for joypad_debounced_controller: directed scenarios with spec constants plus a
// randomized run against a sample-window reference model.
`timescale 1ns/1ps
module tb_joypad_debounced_controller;
    localparam int          SYNC  = 2;
    localparam int          DBW   = 4;
    localparam int          WIN   = 1 << DBW;
    localparam int          LAT   = SYNC + WIN;
    localparam logic [15:0] JADDR = 16'hFF00;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] A;
    logic [7:0]  Di, Do;
    logic        rd_n, wr_n, cs, int_ack, int_req;
    logic [3:0]  dir_n, btn_n;
    logic [1:0]  button_sel;
    logic [7:0]  key_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    joypad_debounced_controller #(
        .ADDR(JADDR), .SYNC_STAGES(SYNC), .DB_CNT_W(DBW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .A(A), .Di(Di), .Do(Do), .rd_n(rd_n),
        .wr_n(wr_n), .cs(cs), .int_ack(int_ack), .int_req(int_req), .dir_n(dir_n),
        .btn_n(btn_n), .button_sel(button_sel), .key_state(key_state)
    );

    // Reference: a key level is accepted once the last WIN synchronised samples all
    // disagree with the accepted level. hist[0] is the newest raw sample.
    logic [7:0] hist [0:WIN];
    logic [7:0] m_stable, m_flip;
    logic [1:0] m_sel;
    logic [3:0] m_prev, m_nib;
    logic       m_int;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= WIN; i++) hist[i] = 8'hFF;
            m_stable = 8'hFF;
            m_sel    = 2'b11;
            m_prev   = 4'hF;
            m_int    = 1'b0;
        end else begin
            m_nib = ({4{m_sel[0]}} | m_stable[3:0]) & ({4{m_sel[1]}} | m_stable[7:4]);
            if (|(m_prev & ~m_nib)) m_int = 1'b1;
            else if (int_ack)       m_int = 1'b0;
            m_prev = m_nib;
            if (!wr_n && cs && A == JADDR) m_sel = Di[5:4];
            m_flip = 8'hFF;
            for (int i = 1; i <= WIN; i++) m_flip = m_flip & (hist[i] ^ m_stable);
            m_stable = m_stable ^ m_flip;
            for (int i = WIN; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {btn_n, dir_n};
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_joyp(input logic [15:0] addr, input logic [7:0] d);
        A = addr; Di = d; wr_n = 1'b0;
        cyc(1);
        wr_n = 1'b1; A = 16'h0000; Di = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cs = 1'b1; A = 16'h0000; Di = 8'h00; rd_n = 1'b1; wr_n = 1'b1;
        int_ack = 1'b0; dir_n = 4'hF; btn_n = 4'hF;
        cyc(3);
        #2 reset_n = 1'b1;
        cyc(2);
        n_tests++; if (Do !== 8'hFF) begin n_fail++; $display("FAIL reset_do: got %h expected ff", Do); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", int_req); end
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL reset_keys: got %h expected ff", key_state); end
        n_tests++; if (button_sel !== 2'b11) begin n_fail++; $display("FAIL reset_sel: got %b expected 11", button_sel); end
    endtask

    task automatic test_debounce();
        write_joyp(JADDR, 8'h20);
        n_tests++; if (Do !== 8'hEF) begin n_fail++; $display("FAIL deb_sel_do: got %h expected ef", Do); end
        dir_n = 4'b1110;
        cyc(LAT - 1);
        n_tests++; if (Do[3:0] !== 4'hF) begin n_fail++; $display("FAIL deb_early: got %h expected f", Do[3:0]); end
        cyc(1);
        n_tests++; if (Do !== 8'hEE) begin n_fail++; $display("FAIL deb_accept: got %h expected ee", Do); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL deb_int_early: got %b expected 0", int_req); end
        cyc(1);
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL deb_int: got %b expected 1", int_req); end
        int_ack = 1'b1; cyc(1); int_ack = 1'b0;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL deb_ack: got %b expected 0", int_req); end
        dir_n = 4'hF;
        cyc(LAT + 2);
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL release_no_int: got %b expected 0", int_req); end
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL release_keys: got %h expected ff", key_state); end
    endtask

    task automatic test_glitch();
        dir_n[0] = 1'b0; cyc(10); dir_n[0] = 1'b1;
        cyc(LAT + 4);
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL glitch10_keys: got %h expected ff", key_state); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL glitch10_int: got %b expected 0", int_req); end
        dir_n[0] = 1'b0; cyc(WIN - 1); dir_n[0] = 1'b1;
        cyc(LAT + 4);
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL glitch15_keys: got %h expected ff", key_state); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL glitch15_int: got %b expected 0", int_req); end
        dir_n[0] = 1'b0; cyc(WIN); dir_n[0] = 1'b1;
        cyc(SYNC);
        n_tests++; if (key_state !== 8'hFE) begin n_fail++; $display("FAIL press16_keys: got %h expected fe", key_state); end
        cyc(LAT);
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL press16_int: got %b expected 1", int_req); end
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL press16_release: got %h expected ff", key_state); end
        int_ack = 1'b1; cyc(1); int_ack = 1'b0;
    endtask

    task automatic test_ack_race();
        write_joyp(JADDR, 8'h10);
        btn_n[1] = 1'b0;
        cyc(LAT + 1);
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL race_pre_int: got %b expected 1", int_req); end
        btn_n[0] = 1'b0;
        cyc(LAT);
        int_ack = 1'b1;
        cyc(1);
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b expected 1", int_req); end
        n_tests++; if (Do !== 8'hDC) begin n_fail++; $display("FAIL race_do: got %h expected dc", Do); end
        cyc(1);
        int_ack = 1'b0;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL race_ack_clear: got %b expected 0", int_req); end
        btn_n = 4'hF;
        cyc(LAT + 2);
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL race_release: got %b expected 0", int_req); end
    endtask

    task automatic test_select_irq();
        write_joyp(JADDR, 8'h30);
        btn_n = 4'b0111;
        cyc(LAT + 2);
        n_tests++; if (key_state !== 8'h7F) begin n_fail++; $display("FAIL sel_keys: got %h expected 7f", key_state); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL sel_hidden_int: got %b expected 0", int_req); end
        n_tests++; if (Do !== 8'hFF) begin n_fail++; $display("FAIL sel_hidden_do: got %h expected ff", Do); end
        write_joyp(JADDR, 8'h10);
        n_tests++; if (Do !== 8'hD7) begin n_fail++; $display("FAIL sel_do: got %h expected d7", Do); end
        cyc(1);
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL sel_int: got %b expected 1", int_req); end
        int_ack = 1'b1; cyc(1); int_ack = 1'b0;
    endtask

    task automatic test_addr_cs();
        write_joyp(JADDR + 16'd1, 8'h30);
        n_tests++; if (button_sel !== 2'b01) begin n_fail++; $display("FAIL addr_plus1: got %b expected 01", button_sel); end
        cs = 1'b0;
        write_joyp(JADDR, 8'h30);
        n_tests++; if (button_sel !== 2'b01) begin n_fail++; $display("FAIL cs0_write: got %b expected 01", button_sel); end
        n_tests++; if (Do !== 8'hFF) begin n_fail++; $display("FAIL cs0_do: got %h expected ff", Do); end
        cs = 1'b1;
        #1;
        n_tests++; if (Do !== 8'hD7) begin n_fail++; $display("FAIL cs1_do: got %h expected d7", Do); end
        write_joyp(JADDR, 8'hCF);
        n_tests++; if (Do !== 8'hC7) begin n_fail++; $display("FAIL di_mask_do: got %h expected c7", Do); end
        btn_n = 4'hF;
        cyc(LAT + 2);
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL addr_release_int: got %b expected 0", int_req); end
    endtask

    task automatic test_reset_midcount();
        write_joyp(JADDR, 8'h20);
        dir_n[2] = 1'b0;
        cyc(10);
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (button_sel !== 2'b11) begin n_fail++; $display("FAIL async_rst_sel: got %b expected 11", button_sel); end
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL async_rst_keys: got %h expected ff", key_state); end
        cyc(2);
        #2 reset_n = 1'b1;
        cyc(LAT - 1);
        n_tests++; if (key_state !== 8'hFF) begin n_fail++; $display("FAIL rst_restart_early: got %h expected ff", key_state); end
        cyc(1);
        n_tests++; if (key_state !== 8'hFB) begin n_fail++; $display("FAIL rst_restart_accept: got %h expected fb", key_state); end
        dir_n = 4'hF;
        cyc(LAT + 2);
    endtask

    task automatic test_random();
        logic [7:0] kv;
        logic [7:0] exp_do;
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            m_nib  = ({4{m_sel[0]}} | m_stable[3:0]) & ({4{m_sel[1]}} | m_stable[7:4]);
            exp_do = cs ? {2'b11, m_sel, m_nib} : 8'hFF;
            n_tests++; if (key_state !== m_stable) begin n_fail++; $display("FAIL rnd_keys c=%0d: got %h expected %h", c, key_state, m_stable); end
            n_tests++; if (Do !== exp_do) begin n_fail++; $display("FAIL rnd_do c=%0d: got %h expected %h", c, Do, exp_do); end
            n_tests++; if (int_req !== m_int) begin n_fail++; $display("FAIL rnd_int c=%0d: got %b expected %b", c, int_req, m_int); end
            n_tests++; if (button_sel !== m_sel) begin n_fail++; $display("FAIL rnd_sel c=%0d: got %b expected %b", c, button_sel, m_sel); end
            reset_n = 1'b1;
            wr_n    = 1'b1;
            int_ack = ($urandom_range(0, 7) == 0);
            cs      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) begin
                wr_n = 1'b0;
                A    = ($urandom_range(0, 3) == 0) ? JADDR + 16'd1 : JADDR;
                Di   = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                kv = {btn_n, dir_n} ^ (8'h01 << $urandom_range(0, 7));
                {btn_n, dir_n} = kv;
            end
            if ($urandom_range(0, 799) == 0) reset_n = 1'b0;
        end
        cyc(1);
        reset_n = 1'b1; wr_n = 1'b1; int_ack = 1'b0; cs = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_ack_race();
        test_select_irq();
        test_addr_cs();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
